// File: rtl/composite_video_gen.sv
// Composite video timing and level generator: line/field counters feed a two-stage
// pipeline (pixel coordinates, then the registered DAC level that merges pixel data).
module composite_video_gen #(
  parameter int LEVEL_W     = 4,
  parameter int BLANK_LEVEL = 1,
  parameter int PIX_DIV     = 4,
  parameter int ACT_X0      = 184,
  parameter int ACT_W       = 560,
  parameter int ACT_Y0      = 40,
  parameter int ACT_H       = 200,
  parameter int H_TOTAL     = 3175,
  parameter int H_HALF      = 1588,
  parameter int FP          = 75,
  parameter int SYNC        = 235,
  parameter int BP          = 235,
  parameter int EQ          = 117,
  parameter int VS          = 1353
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               interlace_i,
  input  logic [LEVEL_W-1:0] pixel_data_i,
  output logic               pixel_valid_o,
  output logic [9:0]         pixel_x_o,
  output logic [9:0]         pixel_y_o,
  output logic               field_o,
  output logic               h_sync_o,
  output logic               v_sync_o,
  output logic [LEVEL_W-1:0] ntsc_out_o
);

  localparam int HC_W  = $clog2(H_TOTAL);
  localparam int PX_SH = $clog2(PIX_DIV);
  localparam logic [LEVEL_W-1:0] BLANK_LVL = LEVEL_W'(BLANK_LEVEL);

  typedef enum logic [1:0] {SLOT_EQ, SLOT_VSYNC, SLOT_BLANK, SLOT_SCAN} slot_t;
  typedef enum logic [1:0] {LVL_SYNC, LVL_BLANK, LVL_VIDEO} lvl_t;

  logic [HC_W-1:0] hc;
  logic [8:0]      line;
  logic            ilace;
  logic [31:0]     hc32;
  logic [31:0]     line32;
  logic [31:0]     px32;
  logic [31:0]     len32;
  logic            half_slot;
  logic            last_slot;
  logic            h_end;
  logic            in_window;
  slot_t           slot;
  lvl_t            lvl;
  lvl_t            lvl_d1;
  logic [9:0]      x_next;
  logic [9:0]      y_next;

  // Slot geometry: interlaced field 0 ends on a half slot, field 1 starts with one.
  always_comb begin
    hc32      = 32'(hc);
    line32    = 32'(line);
    px32      = hc32 >> PX_SH;
    half_slot = ilace && ((!field_o && line == 9'd262) || (field_o && line == 9'd0));
    len32     = half_slot ? H_HALF : H_TOTAL;
    last_slot = ilace ? (line == 9'd262) : (line == 9'd261);
    h_end     = (hc32 == len32 - 32'd1);
  end

  assign h_sync_o = h_end;
  assign v_sync_o = h_end && last_slot;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc      <= '0;
      line    <= '0;
      field_o <= 1'b0;
    end else if (h_end) begin
      hc <= '0;
      if (last_slot) begin
        line    <= '0;
        field_o <= ilace & ~field_o;
      end else begin
        line <= line + 9'd1;
      end
    end else begin
      hc <= hc + HC_W'(1);
    end
  end

  // Mode only changes at a frame boundary (or while reset is held), never mid-frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || (v_sync_o && (field_o || !ilace))) begin
      ilace <= interlace_i;
    end
  end

  always_comb begin
    if (line < 9'd6) begin
      slot = SLOT_EQ;
    end else if (line < 9'd12) begin
      slot = SLOT_VSYNC;
    end else if (line < 9'd18) begin
      slot = SLOT_EQ;
    end else if (line < 9'd20 || half_slot) begin
      slot = SLOT_BLANK;
    end else begin
      slot = SLOT_SCAN;
    end
  end

  always_comb begin
    lvl       = LVL_BLANK;
    in_window = (px32 >= ACT_X0) && (px32 < ACT_X0 + ACT_W) &&
                (line32 >= ACT_Y0) && (line32 < ACT_Y0 + ACT_H);
    case (slot)
      SLOT_EQ: begin
        if (hc32 < EQ || (hc32 >= H_HALF && hc32 < H_HALF + EQ)) lvl = LVL_SYNC;
      end
      SLOT_VSYNC: begin
        if (hc32 < VS || (hc32 >= H_HALF && hc32 < H_HALF + VS)) lvl = LVL_SYNC;
      end
      SLOT_SCAN: begin
        if (hc32 >= FP && hc32 < FP + SYNC) lvl = LVL_SYNC;
        else if (hc32 >= FP + SYNC + BP && in_window) lvl = LVL_VIDEO;
      end
      default: ;
    endcase
    x_next = 10'(px32 - ACT_X0);
    y_next = ilace ? 10'(((line32 - ACT_Y0) << 1) + 32'(field_o)) : 10'(line32 - ACT_Y0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pixel_valid_o <= 1'b0;
      pixel_x_o     <= '0;
      pixel_y_o     <= '0;
      lvl_d1        <= LVL_SYNC;
      ntsc_out_o    <= '0;
    end else begin
      pixel_valid_o <= (lvl == LVL_VIDEO);
      pixel_x_o     <= (lvl == LVL_VIDEO) ? x_next : '0;
      pixel_y_o     <= (lvl == LVL_VIDEO) ? y_next : '0;
      lvl_d1        <= lvl;
      // Pixel data is clamped to black so it can never alias a sync tip.
      case (lvl_d1)
        LVL_SYNC:  ntsc_out_o <= '0;
        LVL_VIDEO: ntsc_out_o <= (pixel_data_i > BLANK_LVL) ? pixel_data_i : BLANK_LVL;
        default:   ntsc_out_o <= BLANK_LVL;
      endcase
    end
  end

endmodule

// File: tb/tb_composite_video_gen.sv
// Bench for composite_video_gen: scaled-down timing, a frame-position model checked
// every cycle, plus directed literal checks on periods, levels, coordinates and reset.
`timescale 1ns/1ps
module tb_composite_video_gen;

  localparam int LW = 4, BLANK = 1, PD = 2;
  localparam int AX0 = 8, AW = 12, AY0 = 40, AH = 200;
  localparam int HT = 48, HH = 24, FP = 2, SY = 6, BP = 6, EQ = 2, VS = 20;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          interlace_i;
  logic [LW-1:0] pixel_data_i;
  logic          pixel_valid_o;
  logic [9:0]    pixel_x_o;
  logic [9:0]    pixel_y_o;
  logic          field_o;
  logic          h_sync_o;
  logic          v_sync_o;
  logic [LW-1:0] ntsc_out_o;

  composite_video_gen #(
    .LEVEL_W(LW), .BLANK_LEVEL(BLANK), .PIX_DIV(PD),
    .ACT_X0(AX0), .ACT_W(AW), .ACT_Y0(AY0), .ACT_H(AH),
    .H_TOTAL(HT), .H_HALF(HH), .FP(FP), .SYNC(SY), .BP(BP), .EQ(EQ), .VS(VS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .interlace_i(interlace_i), .pixel_data_i(pixel_data_i),
    .pixel_valid_o(pixel_valid_o), .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o),
    .field_o(field_o), .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .ntsc_out_o(ntsc_out_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit h_sync; bit v_sync; bit field; bit sync; bit video; bit valid;
    int line; int hc; int x; int y;
  } rec_t;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [LW-1:0] exp_q[$];
  rec_t          cur;
  rec_t          d1;
  int            m_pos;
  bit            m_ilace;
  bit            chk_en = 1'b0;
  bit            ovr_en = 1'b0;
  logic [LW-1:0] ovr_val = '0;

  function automatic int frame_len(bit il);
    return il ? (524 * HT + 2 * HH) : (262 * HT);
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.h_sync = 0; r.v_sync = 0; r.field = 0; r.sync = 1; r.video = 0; r.valid = 0;
    r.line = 0; r.hc = 0; r.x = 0; r.y = 0;
    return r;
  endfunction

  // Position within the frame -> field/line/hc, then the level rules for that point.
  function automatic rec_t decode(int pos, bit il);
    rec_t r;
    int   q, px;
    bit   half, vid;
    r = idle_rec();
    r.sync = 0;
    half = 0;
    if (!il || pos < 262 * HT + HH) begin
      r.field = 0; r.line = pos / HT; r.hc = pos % HT;
      half = il && (r.line == 262);
    end else begin
      q = pos - (262 * HT + HH);
      r.field = 1;
      if (q < HH) begin r.line = 0; r.hc = q; half = 1; end
      else begin r.line = 1 + (q - HH) / HT; r.hc = (q - HH) % HT; end
    end
    r.h_sync = half ? (r.hc == HH - 1) : (r.hc == HT - 1);
    r.v_sync = r.h_sync && (r.line == (il ? 262 : 261));
    if (r.line < 6 || (r.line >= 12 && r.line < 18)) begin
      r.sync = (r.hc < EQ) || (r.hc >= HH && r.hc < HH + EQ);
    end else if (r.line < 12) begin
      r.sync = (r.hc < VS) || (r.hc >= HH && r.hc < HH + VS);
    end else if (r.line >= 20 && !half) begin
      r.sync = (r.hc >= FP && r.hc < FP + SY);
      vid = (r.hc >= FP + SY + BP);
      px = r.hc / PD;
      r.video = vid && px >= AX0 && px < AX0 + AW && r.line >= AY0 && r.line < AY0 + AH;
      if (r.video) begin
        r.valid = 1;
        r.x = px - AX0;
        r.y = il ? (2 * (r.line - AY0) + int'(r.field)) : (r.line - AY0);
      end
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] level(rec_t r, logic [LW-1:0] d);
    if (r.video) return (d > BLANK) ? d : LW'(BLANK);
    if (r.sync) return '0;
    return LW'(BLANK);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, pixel_valid_o, 0);
    chk({name, "_x"}, pixel_x_o, 0);
    chk({name, "_y"}, pixel_y_o, 0);
    chk({name, "_field"}, field_o, 0);
    chk({name, "_hsync"}, h_sync_o, 0);
    chk({name, "_vsync"}, v_sync_o, 0);
    chk({name, "_ntsc"}, ntsc_out_o, 0);
  endtask

  // model + pixel-data driver
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_pos = 0;
      m_ilace = interlace_i;
      cur = decode(0, m_ilace);
      d1 = idle_rec();
      exp_q.delete();
      #1 pixel_data_i = LW'($urandom_range(0, 15));
    end else begin
      exp_q.push_back(level(d1, pixel_data_i));
      d1 = cur;
      if (m_pos + 1 == frame_len(m_ilace)) begin
        m_pos = 0;
        m_ilace = interlace_i;
      end else begin
        m_pos++;
      end
      cur = decode(m_pos, m_ilace);
      #1;
      if (ovr_en) pixel_data_i = ovr_val;
      else if (d1.valid) pixel_data_i = LW'((d1.x + 3 * d1.y) % 16);
      else pixel_data_i = LW'($urandom_range(0, 15));
    end
  end

  // scoreboard compare
  always @(negedge clk_i) begin
    if (chk_en && !rst_i) begin
      chk("h_sync", h_sync_o, cur.h_sync);
      chk("v_sync", v_sync_o, cur.v_sync);
      chk("field", field_o, cur.field);
      chk("pixel_valid", pixel_valid_o, d1.valid);
      chk("pixel_x", pixel_x_o, d1.x);
      chk("pixel_y", pixel_y_o, d1.y);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL ntsc_queue: got empty queue, expected one entry (t=%0t)", $time);
      end else begin
        chk("ntsc", ntsc_out_o, exp_q.pop_front());
      end
    end
  end

  task automatic wait_vsync(output time t);
    int n;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!v_sync_o && n < 20000);
    if (!v_sync_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL vsync_timeout: got no v_sync_o in %0d cycles, expected a pulse", n);
    end
    t = $time;
  endtask

  task automatic wait_model(input bit f, input int l, input int h);
    int n;
    n = 0;
    do begin @(negedge clk_i); n++; end
    while (!(cur.field == f && cur.line == l && cur.hc == h) && n < 30000);
    if (n >= 30000) begin
      n_checks++;
      n_errors++;
      $display("FAIL model_timeout: got no field %0d line %0d hc %0d, expected to reach it", f, l, h);
    end
  endtask

  initial begin
    time t_rel, t1, t2, t3;
    int  n;
    rst_i = 1'b1;
    interlace_i = 1'b1;
    pixel_data_i = '0;
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_i = 1'b0;
    t_rel = $time;
    @(posedge clk_i); #1 chk_en = 1'b1;

    // VSYNC line 7: sync for VS clocks, blank until HH, then sync again
    wait_model(1'b0, 7, 0);
    @(negedge clk_i); @(negedge clk_i);
    for (int k = 0; k < 26; k++) begin
      if (k == 0 || k == 19 || k == 20 || k == 23 || k == 24 || k == 25)
        chk("line7_level", ntsc_out_o, (k >= 20 && k < 24) ? 1 : 0);
      @(negedge clk_i);
    end

    // field 0 = 262 full lines + one half line; release cycle is position 0
    wait_vsync(t1);
    chk("field0_end_pos", int'((t1 - t_rel) / 10), 12599);
    @(negedge clk_i);
    chk("field_after_f0", field_o, 1);

    // line 50 of field 1, first active pixel: y = 2*(50-40)+1
    wait_model(1'b1, 50, 16);
    ovr_val = 4'hF; ovr_en = 1'b1;
    @(negedge clk_i);
    chk("l50_valid", pixel_valid_o, 1);
    chk("l50_x", pixel_x_o, 0);
    chk("l50_y", pixel_y_o, 21);
    ovr_val = 4'h0;
    @(negedge clk_i);
    chk("l50_ntsc_F", ntsc_out_o, 15);
    @(negedge clk_i);
    chk("l50_ntsc_black", ntsc_out_o, 1);
    ovr_en = 1'b0;

    // switch to progressive; takes effect only at the end of field 1
    interlace_i = 1'b0;
    wait_vsync(t2);
    chk("field1_period", int'((t2 - t1) / 10), 12600);
    @(negedge clk_i);
    chk("field_after_f1", field_o, 0);

    repeat (3000) @(negedge clk_i);
    interlace_i = 1'b1;
    chk("prog_field", field_o, 0);
    wait_vsync(t3);
    chk("prog_period", int'((t3 - t2) / 10), 12576);

    // asynchronous reset mid-line on an active pixel
    wait_model(1'b0, 100, 30);
    @(posedge clk_i);
    #3 chk_en = 1'b0;
    rst_i = 1'b1;
    #1 chk_all_zero("midline_reset");
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1 chk_en = 1'b1;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!h_sync_o && n < 200);
    chk("hsync_after_reset", n, 47);
    repeat (100) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
